// File: rtl/block_sync_pkg.sv
// block_sync_pkg
//   Shared definitions for the block_sync stage (block_lock_fsm and
//   block_sync_timer): lock FSM state encoding, the two legal 64b/66b sync
//   header codes, and the default window lengths and invalid-header limit.
//   No ports.
package block_sync_pkg;

    typedef enum logic [1:0] {
        LOCK_INIT = 2'd0,
        RESET_CNT = 2'd1,
        TEST_SH   = 2'd2,
        SLIP      = 2'd3
    } lock_state_e;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    localparam int UNLOCKED_WINDOW_DEFAULT = 64;
    localparam int LOCKED_WINDOW_DEFAULT   = 1024;
    localparam int MAX_INVALID_SH_DEFAULT  = 65;

    // A header is valid only when its two bits differ.
    function automatic logic is_sync_header(input logic [1:0] sh);
        return (sh == SH_DATA) || (sh == SH_CTRL);
    endfunction

endpackage

// File: rtl/block_lock_fsm_if.sv
// block_lock_fsm_if
//   Bundle of the lock FSM's handshake signals as seen by the block_sync
//   stage. The master modport is the side that presents headers and timer
//   status (parent stage or a bench); the slave modport is the lock FSM view.
//   Signals:
//     enable, valid, sh_valid             lane enable and header strobe/quality
//     unlocked_count_done, locked_count_done  window-closing flags from the timer
//     slip_done                           aligner finished a one-bit slip
//     block_lock, slip                    lock status and slip request
//     timer_reset_count, timer_enable     control for block_sync_timer
interface block_lock_fsm_if;
    logic enable;
    logic valid;
    logic sh_valid;
    logic unlocked_count_done;
    logic locked_count_done;
    logic slip_done;
    logic block_lock;
    logic slip;
    logic timer_reset_count;
    logic timer_enable;

    modport master (
        output enable, valid, sh_valid, unlocked_count_done,
               locked_count_done, slip_done,
        input  block_lock, slip, timer_reset_count, timer_enable
    );

    modport slave (
        input  enable, valid, sh_valid, unlocked_count_done,
               locked_count_done, slip_done,
        output block_lock, slip, timer_reset_count, timer_enable
    );
endinterface

// File: rtl/block_lock_fsm.sv
// block_lock_fsm
//   64b/66b block-lock state machine. Tests one sync header per i_valid
//   strobe while in TEST_SH, acquires lock after a clean 64-header window,
//   drops lock after MAX_INVALID_SH bad headers inside one 1024-header
//   window, and requests single-bit slips from the aligner while hunting.
//   Ports:
//     i_clock, i_reset        clock, asynchronous active-high reset
//     i_enable                lane enable (low forces LOCK_INIT)
//     i_valid, i_sh_valid     header strobe and header quality
//     i_unlocked_count_done   header closes the 64-header window
//     i_locked_count_done     header closes the 1024-header window
//     i_slip_done             aligner completed a slip
//     o_block_lock            lane is block-locked
//     o_slip                  one-cycle slip request
//     o_timer_reset_count     block_sync_timer reset-count control
//     o_timer_enable          block_sync_timer enable
module block_lock_fsm
    import block_sync_pkg::*;
#(
    parameter int MAX_INVALID_SH = MAX_INVALID_SH_DEFAULT
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_enable,
    input  logic i_valid,
    input  logic i_sh_valid,
    input  logic i_unlocked_count_done,
    input  logic i_locked_count_done,
    input  logic i_slip_done,
    output logic o_block_lock,
    output logic o_slip,
    output logic o_timer_reset_count,
    output logic o_timer_enable
);

    localparam int NB_INVALID = $clog2(MAX_INVALID_SH + 1);
    localparam logic [NB_INVALID-1:0] INVALID_LIMIT = NB_INVALID'(MAX_INVALID_SH);

    lock_state_e           state_q;
    logic                  block_lock_q;
    logic                  slip_q;
    logic [NB_INVALID-1:0] invalid_cnt_q;
    logic [NB_INVALID-1:0] invalid_cnt_d;

    // Saturating increment so the counter can never wrap back to zero.
    always_comb begin
        invalid_cnt_d = invalid_cnt_q;
        if (invalid_cnt_q != INVALID_LIMIT) begin
            invalid_cnt_d = invalid_cnt_q + NB_INVALID'(1);
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= LOCK_INIT;
            block_lock_q  <= 1'b0;
            slip_q        <= 1'b0;
            invalid_cnt_q <= '0;
        end else begin
            // o_slip is a pulse: only the transition into SLIP raises it.
            slip_q <= 1'b0;
            if (!i_enable) begin
                state_q       <= LOCK_INIT;
                block_lock_q  <= 1'b0;
                invalid_cnt_q <= '0;
            end else begin
                case (state_q)
                    LOCK_INIT: begin
                        block_lock_q  <= 1'b0;
                        invalid_cnt_q <= '0;
                        state_q       <= RESET_CNT;
                    end
                    RESET_CNT: begin
                        invalid_cnt_q <= '0;
                        state_q       <= TEST_SH;
                    end
                    TEST_SH: begin
                        if (i_valid) begin
                            if (i_sh_valid) begin
                                // Clean window closing wins over the locked window.
                                if (i_unlocked_count_done && (invalid_cnt_q == '0)) begin
                                    block_lock_q <= 1'b1;
                                    state_q      <= RESET_CNT;
                                end else if (i_locked_count_done) begin
                                    state_q <= RESET_CNT;
                                end
                            end else if (!block_lock_q) begin
                                state_q <= SLIP;
                                slip_q  <= 1'b1;
                            end else begin
                                invalid_cnt_q <= invalid_cnt_d;
                                if (invalid_cnt_d == INVALID_LIMIT) begin
                                    block_lock_q <= 1'b0;
                                    state_q      <= SLIP;
                                    slip_q       <= 1'b1;
                                end else if (i_locked_count_done) begin
                                    state_q <= RESET_CNT;
                                end
                            end
                        end
                    end
                    SLIP: begin
                        if (i_slip_done) begin
                            state_q <= RESET_CNT;
                        end
                    end
                    default: state_q <= LOCK_INIT;
                endcase
            end
        end
    end

    assign o_block_lock        = block_lock_q;
    assign o_slip              = slip_q;
    assign o_timer_reset_count = (state_q != TEST_SH);
    assign o_timer_enable      = (state_q == TEST_SH);

endmodule

// File: tb/tb_block_lock_fsm.sv
module tb_block_lock_fsm;

    localparam int MAX_BAD = 65;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    block_lock_fsm_if bus ();

    block_lock_fsm #(.MAX_INVALID_SH(MAX_BAD)) dut (
        .i_clock               (clk),
        .i_reset               (rst),
        .i_enable              (bus.enable),
        .i_valid               (bus.valid),
        .i_sh_valid            (bus.sh_valid),
        .i_unlocked_count_done (bus.unlocked_count_done),
        .i_locked_count_done   (bus.locked_count_done),
        .i_slip_done           (bus.slip_done),
        .o_block_lock          (bus.block_lock),
        .o_slip                (bus.slip),
        .o_timer_reset_count   (bus.timer_reset_count),
        .o_timer_enable        (bus.timer_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference ----------------
    // The lane is either off, restarting a window, hunting headers, or
    // waiting for the aligner. Lock and the bad-header tally are plain ints.
    typedef enum int {M_OFF, M_RESTART, M_HUNT, M_SLIPPING} mphase_t;
    mphase_t m_phase;
    bit      m_lock;
    bit      m_slip;
    int      m_bad;

    task automatic model_reset();
        m_phase = M_OFF;
        m_lock  = 0;
        m_slip  = 0;
        m_bad   = 0;
    endtask

    task automatic model_step(input bit en, v, shv, ud, ld, sd);
        bit pulse = 0;
        if (!en) begin
            m_phase = M_OFF; m_lock = 0; m_bad = 0;
        end else if (m_phase == M_OFF) begin
            m_phase = M_RESTART; m_lock = 0; m_bad = 0;
        end else if (m_phase == M_RESTART) begin
            m_bad = 0; m_phase = M_HUNT;
        end else if (m_phase == M_SLIPPING) begin
            if (sd) m_phase = M_RESTART;
        end else if (v) begin
            if (shv) begin
                if (ud && m_bad == 0) begin m_lock = 1; m_phase = M_RESTART; end
                else if (ld) m_phase = M_RESTART;
            end else if (!m_lock) begin
                m_phase = M_SLIPPING; pulse = 1;
            end else begin
                m_bad = (m_bad + 1 > MAX_BAD) ? MAX_BAD : m_bad + 1;
                if (m_bad == MAX_BAD) begin m_lock = 0; m_phase = M_SLIPPING; pulse = 1; end
                else if (ld) m_phase = M_RESTART;
            end
        end
        m_slip = pulse;
    endtask

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic drive(input bit en, v, shv, ud, ld, sd);
        bus.enable              = en;
        bus.valid               = v;
        bus.sh_valid            = shv;
        bus.unlocked_count_done = ud;
        bus.locked_count_done   = ld;
        bus.slip_done           = sd;
        @(posedge clk);
        model_step(en, v, shv, ud, ld, sd);
        #1;
    endtask

    task automatic do_reset(input bit en);
        rst = 1'b1;
        bus.enable = en; bus.valid = 0; bus.sh_valid = 0;
        bus.unlocked_count_done = 0; bus.locked_count_done = 0; bus.slip_done = 0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Reset, then two idle cycles: off -> restart -> hunting.
    task automatic bring_up();
        do_reset(1'b1);
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
    endtask

    // Bring up and send a clean 64-header window; ends locked, restarting.
    task automatic acquire(input bit both_done);
        bring_up();
        for (int i = 0; i < 63; i++) drive(1, 1, 1, 0, 0, 0);
        drive(1, 1, 1, 1, both_done, 0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        bus.enable = 0; bus.valid = 0; bus.sh_valid = 0;
        bus.unlocked_count_done = 0; bus.locked_count_done = 0; bus.slip_done = 0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checks++; if (bus.block_lock !== 1'b0) begin errors++; $display("FAIL reset_lock got %b exp 0", bus.block_lock); end
        checks++; if (bus.slip !== 1'b0) begin errors++; $display("FAIL reset_slip got %b exp 0", bus.slip); end
        checks++; if (bus.timer_reset_count !== 1'b1) begin errors++; $display("FAIL reset_trc got %b exp 1", bus.timer_reset_count); end
        checks++; if (bus.timer_enable !== 1'b0) begin errors++; $display("FAIL reset_ten got %b exp 0", bus.timer_enable); end
        @(posedge clk); #1;
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_acquire();
        bit saw_slip = 0;
        bring_up();
        checks++; if (bus.timer_enable !== 1'b1) begin errors++; $display("FAIL acquire_hunt_ten got %b exp 1", bus.timer_enable); end
        for (int i = 0; i < 63; i++) begin
            drive(1, 1, 1, 0, 0, 0);
            if (bus.slip) saw_slip = 1;
        end
        checks++; if (bus.block_lock !== 1'b0) begin errors++; $display("FAIL acquire_early_lock got %b exp 0", bus.block_lock); end
        drive(1, 1, 1, 1, 0, 0);
        if (bus.slip) saw_slip = 1;
        checks++; if (bus.block_lock !== 1'b1) begin errors++; $display("FAIL acquire_lock got %b exp 1", bus.block_lock); end
        checks++; if (saw_slip !== 1'b0) begin errors++; $display("FAIL acquire_no_slip got %b exp 0", saw_slip); end
        checks++; if (bus.timer_reset_count !== 1'b1) begin errors++; $display("FAIL acquire_restart_trc got %b exp 1", bus.timer_reset_count); end
        $display("test_acquire done");
    endtask

    task automatic test_slip();
        bring_up();
        for (int i = 0; i < 10; i++) drive(1, 1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0);
        checks++; if (bus.slip !== 1'b1) begin errors++; $display("FAIL slip_pulse got %b exp 1", bus.slip); end
        checks++; if (bus.timer_reset_count !== 1'b1) begin errors++; $display("FAIL slip_trc got %b exp 1", bus.timer_reset_count); end
        drive(1, 0, 0, 0, 0, 0);
        checks++; if (bus.slip !== 1'b0) begin errors++; $display("FAIL slip_one_cycle got %b exp 0", bus.slip); end
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0);
        checks++; if (bus.timer_enable !== 1'b0) begin errors++; $display("FAIL slip_waiting_ten got %b exp 0", bus.timer_enable); end
        drive(1, 0, 0, 0, 0, 1);
        checks++; if ({bus.timer_reset_count, bus.timer_enable} !== 2'b10) begin errors++; $display("FAIL slip_done_restart got %b exp 10", {bus.timer_reset_count, bus.timer_enable}); end
        drive(1, 0, 0, 0, 0, 0);
        checks++; if (bus.timer_enable !== 1'b1) begin errors++; $display("FAIL slip_back_to_hunt got %b exp 1", bus.timer_enable); end
        checks++; if (bus.block_lock !== 1'b0) begin errors++; $display("FAIL slip_lock got %b exp 0", bus.block_lock); end
        $display("test_slip done");
    endtask

    task automatic test_invalid_window();
        acquire(1'b0);
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 1024; i++) begin
            drive(1, 1, (i % 16) != 0, 0, i == 1023, 0);
        end
        checks++; if (bus.block_lock !== 1'b1) begin errors++; $display("FAIL window64_lock got %b exp 1", bus.block_lock); end
        checks++; if (bus.timer_reset_count !== 1'b1) begin errors++; $display("FAIL window64_restart got %b exp 1", bus.timer_reset_count); end
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 64; i++) drive(1, 1, 0, 0, 0, 0);
        checks++; if (bus.block_lock !== 1'b1) begin errors++; $display("FAIL window_cleared_lock got %b exp 1", bus.block_lock); end
        drive(1, 1, 0, 0, 0, 0);
        checks++; if (bus.block_lock !== 1'b0) begin errors++; $display("FAIL window65_lock got %b exp 0", bus.block_lock); end
        checks++; if (bus.slip !== 1'b1) begin errors++; $display("FAIL window65_slip got %b exp 1", bus.slip); end
        $display("test_invalid_window done");
    endtask

    task automatic test_enable_drop();
        acquire(1'b1);
        checks++; if (bus.block_lock !== 1'b1) begin errors++; $display("FAIL both_done_lock got %b exp 1", bus.block_lock); end
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        checks++; if (bus.block_lock !== 1'b0) begin errors++; $display("FAIL enable_drop_lock got %b exp 0", bus.block_lock); end
        checks++; if ({bus.timer_reset_count, bus.timer_enable} !== 2'b10) begin errors++; $display("FAIL enable_drop_timer got %b exp 10", {bus.timer_reset_count, bus.timer_enable}); end
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        checks++; if (bus.timer_enable !== 1'b1) begin errors++; $display("FAIL enable_return_hunt got %b exp 1", bus.timer_enable); end
        $display("test_enable_drop done");
    endtask

    task automatic test_reset_in_slip();
        bit saw_slip = 0;
        bring_up();
        drive(1, 1, 0, 0, 0, 0);
        checks++; if (bus.slip !== 1'b1) begin errors++; $display("FAIL rslip_enter got %b exp 1", bus.slip); end
        bus.slip_done = 1'b1;
        rst = 1'b1;
        #1;
        model_reset();
        checks++; if (bus.slip !== 1'b0) begin errors++; $display("FAIL rslip_async_slip got %b exp 0", bus.slip); end
        checks++; if (bus.timer_reset_count !== 1'b1) begin errors++; $display("FAIL rslip_async_trc got %b exp 1", bus.timer_reset_count); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 0);
            if (bus.slip) saw_slip = 1;
            if (i == 0) begin
                checks++; if (bus.timer_enable !== 1'b0) begin errors++; $display("FAIL rslip_restart_ten got %b exp 0", bus.timer_enable); end
            end
        end
        checks++; if (saw_slip !== 1'b0) begin errors++; $display("FAIL rslip_residual got %b exp 0", saw_slip); end
        checks++; if (bus.timer_enable !== 1'b1) begin errors++; $display("FAIL rslip_hunt got %b exp 1", bus.timer_enable); end
        $display("test_reset_in_slip done");
    endtask

    task automatic test_ignored();
        bit saw_slip = 0;
        acquire(1'b0);
        drive(1, 1, 0, 0, 0, 0);
        checks++; if (bus.block_lock !== 1'b1) begin errors++; $display("FAIL ign_restart_lock got %b exp 1", bus.block_lock); end
        for (int i = 0; i < 64; i++) drive(1, 1, 0, 0, 0, 0);
        checks++; if (bus.block_lock !== 1'b1) begin errors++; $display("FAIL ign_count_unchanged got %b exp 1", bus.block_lock); end
        drive(1, 1, 0, 0, 0, 0);
        checks++; if (bus.slip !== 1'b1) begin errors++; $display("FAIL ign_limit_slip got %b exp 1", bus.slip); end
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, i[0], 1, 1, 0);
            if (bus.slip) saw_slip = 1;
        end
        checks++; if (saw_slip !== 1'b0) begin errors++; $display("FAIL ign_slip_repulse got %b exp 0", saw_slip); end
        checks++; if (bus.timer_enable !== 1'b0) begin errors++; $display("FAIL ign_stay_slip got %b exp 0", bus.timer_enable); end
        drive(1, 1, 1, 0, 0, 1);
        checks++; if ({bus.block_lock, bus.timer_reset_count, bus.timer_enable} !== 3'b010) begin errors++; $display("FAIL ign_slip_exit got %b exp 010", {bus.block_lock, bus.timer_reset_count, bus.timer_enable}); end
        $display("test_ignored done");
    endtask

    task automatic test_random();
        bit en, v, shv, ud, ld, sd;
        logic [3:0] exp_o;
        int bad_before = errors;
        bring_up();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(999) == 0) do_reset(1'b1);
            en  = ($urandom_range(99) != 0);
            v   = ($urandom_range(9) < 7);
            shv = ((i / 500) % 2 == 0) ? ($urandom_range(19) != 0) : ($urandom_range(2) != 0);
            ud  = ($urandom_range(15) == 0);
            ld  = ($urandom_range(99) == 0);
            sd  = ($urandom_range(4) == 0);
            drive(en, v, shv, ud, ld, sd);
            exp_o = {m_lock, m_slip, m_phase != M_HUNT, m_phase == M_HUNT};
            checks++;
            if ({bus.block_lock, bus.slip, bus.timer_reset_count, bus.timer_enable} !== exp_o) begin
                errors++;
                $display("FAIL random_cycle_%0d got %b exp %b", i,
                         {bus.block_lock, bus.slip, bus.timer_reset_count, bus.timer_enable}, exp_o);
            end
        end
        $display("test_random done, new errors %0d", errors - bad_before);
    endtask

    initial begin
        rst = 1'b0;
        model_reset();
        test_reset();
        test_acquire();
        test_slip();
        test_invalid_window();
        test_enable_drop();
        test_reset_in_slip();
        test_ignored();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
